mux_seq_nx1: RTL

Parametrised, registered N:1 multiplexer with a built-in scan sequencer, generalising the team's fixed 8:1 bit mux. In select mode it registers one W-bit lane of an N-lane input bus chosen by `sel`. In scan mode it snapshots all lanes on `start` and streams them out in ascending index order over a valid/ready handshake, acting as a parallel-to-serial stage in front of downstream serial consumers.

---
 rtl/mux_seq_pkg.sv | 18 +
 rtl/mux_seq_nx1_if.sv | 31 +++
 rtl/mux_seq_nx1_mux.sv | 24 ++
 rtl/mux_seq_nx1.sv | 109 ++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the registered N:1 mux with scan sequencer.
// The select/index width helper is shared by the interface, the top level and the lane selector.
package mux_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } mux_seq_state_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam mux_seq_state_t RST_STATE = IDLE;
    localparam logic           RST_VALID = 1'b0;
    localparam logic           RST_BUSY  = 1'b0;

endpackage

// File: rtl/mux_seq_nx1_if.sv
// Bus bundle for mux_seq_nx1: lane inputs, select/start controls and the scan output handshake.
// The o_last signal exists only when MUX_SEQ_LAST_EN is defined.
interface mux_seq_nx1_if
    import mux_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = sel_width(N)
);
    logic [N*W-1:0] i;
    logic [SW-1:0]  sel;
    logic           start;
    logic [W-1:0]   o;
    logic           o_valid;
    logic           o_ready;
    logic [SW-1:0]  s_cur;
    logic           busy;
`ifdef MUX_SEQ_LAST_EN
    logic           o_last;

    modport master (output i, sel, start, o_ready,
                    input  o, o_valid, s_cur, busy, o_last);
    modport slave  (input  i, sel, start, o_ready,
                    output o, o_valid, s_cur, busy, o_last);
`else
    modport master (output i, sel, start, o_ready,
                    input  o, o_valid, s_cur, busy);
    modport slave  (input  i, sel, start, o_ready,
                    output o, o_valid, s_cur, busy);
`endif
endinterface

// File: rtl/mux_seq_nx1_mux.sv
// Combinational N:1 lane selector, W bits per lane.
// Out-of-range selects (possible when N is not a power of two) yield zero.
module mux_nx1
    import mux_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = sel_width(N)
) (
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   lane
);

    always_comb begin
        lane = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                lane = i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_seq_nx1.sv
// Registered N:1 mux with a snapshot-based parallel-to-serial scan sequencer.
// Optional o_last flag is built when MUX_SEQ_LAST_EN is defined.
//
// state | meaning
// IDLE  | o follows lane sel each cycle; start snapshots i and emits lane 0
// SCAN  | stream snapshot lanes 0..N-1 over o_valid/o_ready, return to IDLE after last
module mux_seq_nx1
    import mux_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux_seq_nx1_if.slave  bus
);

    localparam int            SW       = sel_width(N);
    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

    mux_seq_state_t state_q, state_d;
    logic [N*W-1:0] snap_q, snap_d;
    logic [W-1:0]   o_q, o_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic [SW-1:0]  s_q, s_d;
    logic [SW-1:0]  nxt_idx;
    logic [W-1:0]   live_lane;
    logic [W-1:0]   snap_lane;

    // Next index wraps harmlessly for power-of-two N; it is never used after the last lane.
    assign nxt_idx = s_q + SW'(1);

    mux_nx1 #(.N(N), .W(W), .SW(SW)) u_live (
        .i    (bus.i),
        .sel  (bus.sel),
        .lane (live_lane)
    );

    mux_nx1 #(.N(N), .W(W), .SW(SW)) u_snap (
        .i    (snap_q),
        .sel  (nxt_idx),
        .lane (snap_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            snap_q  <= '0;
            o_q     <= '0;
            valid_q <= RST_VALID;
            busy_q  <= RST_BUSY;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        o_d     = o_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        s_d     = s_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.i;
                    o_d     = bus.i[W-1:0];
                    s_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end else begin
                    o_d = live_lane;
                    s_d = bus.sel;
                end
            end
            SCAN: begin
                if (valid_q && bus.o_ready) begin
                    if (s_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        s_d = nxt_idx;
                        o_d = snap_lane;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o       = o_q;
    assign bus.o_valid = valid_q;
    assign bus.s_cur   = s_q;
    assign bus.busy    = busy_q;
`ifdef MUX_SEQ_LAST_EN
    assign bus.o_last  = valid_q && (s_q == LAST_IDX);
`endif

endmodule
